// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: hit/miss sequencer for the 2-way data cache SRAM.
// Optional perf counters: define DCACHE_MISS_CTRL_PERF_EN.
module dcache_miss_ctrl #(
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [24:0]       sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic [24:0]       sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_MISS_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_miss_o,
  output logic [31:0]       perf_wb_o
`endif
);

  localparam int OFS_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = 32 - IDX_W - OFS_W;
  localparam int WSEL_W = OFS_W - $clog2(WORD_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [31-OFS_W:0]  req_line_q;
  logic [TAG_W-1:0]   vic_tag_q;
  logic [LINE_W-1:0]  vic_line_q;
  logic [LINE_W-1:0]  fill_line_q;
  logic               mem_req_q;
  logic               mem_we_q;

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   cpu_idx;
  logic [WSEL_W-1:0]  wsel;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               miss;
  logic               dirty_vic;
  logic               ack;
  logic               unused_ok;

  assign cpu_tag   = cpu_addr_i[31 -: TAG_W];
  assign cpu_idx   = cpu_addr_i[OFS_W +: IDX_W];
  assign wsel      = cpu_addr_i[OFS_W-1 -: WSEL_W];
  assign req_tag   = req_line_q[31-OFS_W -: TAG_W];
  assign req_idx   = req_line_q[IDX_W-1:0];
  assign miss      = cpu_req_i & ~sram_hit_i;
  assign dirty_vic = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
  assign unused_ok = ^cpu_addr_i[1:0];

  // Acks are only meaningful while a request is actually outstanding.
  assign ack = mem_ack_i & mem_req_q &
               ((state_q == WB) | (state_q == REFILL));

  assign cpu_stall_o = cpu_req_i & ((state_q != IDLE) | ~sram_hit_i);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_data_o  = vic_line_q;

  always_comb begin
    state_d       = state_q;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = cpu_idx;
    sram_tag_o    = {2'b00, cpu_tag};
    sram_data_o   = sram_data_i;
    cpu_data_o    = '0;
    mem_addr_o    = '0;
    unique case (state_q)
      IDLE: begin
        sram_enable_o = cpu_req_i;
        cpu_data_o    = sram_data_i[wsel*WORD_W +: WORD_W];
        if (cpu_req_i & sram_hit_i & cpu_we_i) begin
          sram_write_o = 1'b1;
          sram_data_o[wsel*WORD_W +: WORD_W] = cpu_data_i;
        end
        if (miss)
          state_d = dirty_vic ? WB : REFILL;
      end
      WB: begin
        mem_addr_o = {vic_tag_q, req_idx, {OFS_W{1'b0}}};
        if (ack)
          state_d = REFILL;
      end
      REFILL: begin
        mem_addr_o = {req_tag, req_idx, {OFS_W{1'b0}}};
        if (ack)
          state_d = FILL;
      end
      FILL: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        sram_addr_o   = req_idx;
        sram_tag_o    = {2'b00, req_tag};
        sram_data_o   = fill_line_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request drops for one cycle after every ack, even WB -> REFILL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      req_line_q  <= '0;
      vic_tag_q   <= '0;
      vic_line_q  <= '0;
      fill_line_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= ((state_d == WB) | (state_d == REFILL)) & ~ack;
      mem_we_q  <= (state_d == WB);
      if ((state_q == IDLE) && miss) begin
        req_line_q <= cpu_addr_i[31:OFS_W];
        if (dirty_vic) begin
          vic_tag_q  <= sram_tag_i[TAG_W-1:0];
          vic_line_q <= sram_data_i;
        end
      end
      if ((state_q == REFILL) && ack)
        fill_line_q <= mem_data_i;
    end
  end

`ifdef DCACHE_MISS_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
      perf_wb_o   <= '0;
    end else begin
      if ((state_q == IDLE) && cpu_req_i && sram_hit_i)
        perf_hit_o <= perf_hit_o + 32'd1;
      if ((state_q == IDLE) && miss)
        perf_miss_o <= perf_miss_o + 32'd1;
      if ((state_q == WB) && ack)
        perf_wb_o <= perf_wb_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: cache SRAM + memory models around dcache_miss_ctrl.
// Access vectors come from a table; corner cases are hand sequences.
module tb_dcache_miss_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_MISS_CTRL_PERF_EN
  logic [31:0]  perf_hit_o, perf_miss_o, perf_wb_o;
`endif

  dcache_miss_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_MISS_CTRL_PERF_EN
    ,
    .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o),
    .perf_wb_o(perf_wb_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference contents of memory as seen by the CPU
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] pat_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = pat_word({a[31:5], 5'b0} + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = ref_word({a[31:5], 5'b0} + 32'(w * 4));
    return l;
  endfunction

  // 2-way cache SRAM model
  logic         s_val [16][2];
  logic         s_dty [16][2];
  logic [22:0]  s_tag [16][2];
  logic [255:0] s_dat [16][2];
  logic         s_lru [16];
  logic         s_hit;
  logic         s_hw;
  logic         s_way;

  initial begin
    for (int i = 0; i < 16; i++) begin
      s_lru[i] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        s_val[i][j] = 1'b0;
        s_dty[i][j] = 1'b0;
        s_tag[i][j] = '0;
        s_dat[i][j] = '0;
      end
    end
  end

  always_comb begin
    s_hit = 1'b0;
    s_hw  = 1'b0;
    if (s_val[sram_addr_o][0] && s_tag[sram_addr_o][0] == sram_tag_o[22:0])
      s_hit = 1'b1;
    else if (s_val[sram_addr_o][1] &&
             s_tag[sram_addr_o][1] == sram_tag_o[22:0]) begin
      s_hit = 1'b1;
      s_hw  = 1'b1;
    end
    s_way = s_hit ? s_hw : s_lru[sram_addr_o];
    sram_hit_i  = s_hit;
    sram_tag_i  = {s_val[sram_addr_o][s_way], s_dty[sram_addr_o][s_way],
                   s_tag[sram_addr_o][s_way]};
    sram_data_i = s_dat[sram_addr_o][s_way];
  end

  always @(posedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      if (s_hit) begin
        s_dat[sram_addr_o][s_hw] <= sram_data_o;
        s_dty[sram_addr_o][s_hw] <= 1'b1;
        s_lru[sram_addr_o] <= ~s_hw;
      end else begin
        s_val[sram_addr_o][s_way] <= 1'b1;
        s_dty[sram_addr_o][s_way] <= 1'b0;
        s_tag[sram_addr_o][s_way] <= sram_tag_o[22:0];
        s_dat[sram_addr_o][s_way] <= sram_data_o;
        s_lru[sram_addr_o] <= ~s_way;
      end
    end else if (sram_enable_o && s_hit) begin
      s_lru[sram_addr_o] <= ~s_hw;
    end
  end

  // Main memory model: ack arrives lat cycles after request first seen
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } rec_t;

  rec_t         mem_log[$];
  logic [255:0] bmem [logic [31:0]];
  int           rd_lat = 4;
  int           wb_lat = 4;
  int           mcnt = 0;
  logic         model_ack = 1'b0;
  logic         force_ack = 1'b0;
  logic [255:0] rdata_q = '0;
  logic [255:0] rline;

  assign mem_ack_i  = model_ack | force_ack;
  assign mem_data_i = rdata_q;

  always @(posedge clk_i) begin
    if (rst_i) begin
      mcnt      <= 0;
      model_ack <= 1'b0;
    end else if (model_ack) begin
      model_ack <= 1'b0;
      mcnt      <= 0;
    end else if (mem_req_o) begin
      if (mcnt + 1 >= (mem_we_o ? wb_lat : rd_lat)) begin
        model_ack <= 1'b1;
        mcnt      <= 0;
        if (mem_we_o) begin
          bmem[mem_addr_o] = mem_data_o;
          mem_log.push_back('{1'b1, mem_addr_o, mem_data_o});
        end else begin
          rline = bmem.exists(mem_addr_o) ? bmem[mem_addr_o]
                                          : line_pat(mem_addr_o);
          rdata_q <= rline;
          mem_log.push_back('{1'b0, mem_addr_o, rline});
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        wb;
    logic [31:0] vaddr;
  } vec_t;

  vec_t        vec[17];
  logic [31:0] exp_q[$];

  task automatic pop_log(output rec_t r, output bit ok);
    ok = mem_log.size() > 0;
    chk("mem_txn_present", 256'(ok), 256'(1));
    if (ok) r = mem_log.pop_front();
  endtask

  task automatic access(input vec_t v);
    int n;
    logic [31:0]  exp_d;
    logic [255:0] exp_vl;
    rec_t r;
    bit ok;
    exp_vl = ref_line(v.vaddr);
    exp_q.push_back(v.we ? 32'h0 : ref_word(v.addr));
    if (v.we) ref_mem[v.addr] = v.wdata;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_data_i = v.wdata;
    #1;
    n = 0;
    while (cpu_stall_o && n < 300) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 300) $display("FAIL stall_timeout: got %0d cycles", n);
    chk("stall_cycles", 256'(n), 256'(v.stall));
    exp_d = exp_q.pop_front();
    if (!v.we) chk("load_data", 256'(cpu_data_o), 256'(exp_d));
    chk("sram_write", 256'(sram_write_o), 256'(v.we));
    if (v.wb) begin
      pop_log(r, ok);
      if (ok) begin
        chk("wb_we", 256'(r.we), 256'(1));
        chk("wb_addr", 256'(r.addr), 256'(v.vaddr));
        chk("wb_data", r.data, exp_vl);
      end
    end
    if (v.stall > 0) begin
      pop_log(r, ok);
      if (ok) begin
        chk("refill_we", 256'(r.we), 256'(0));
        chk("refill_addr", 256'(r.addr), 256'({v.addr[31:5], 5'b0}));
      end
    end
    chk("no_extra_txn", 256'(mem_log.size()), 256'(0));
    exp_hit++;
    if (v.stall > 0) exp_miss++;
    if (v.wb) exp_wb++;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    logic [31:0]  a0;
    logic [255:0] d0;
    int t;

    vec[0]  = '{1'b0, 32'h0000_0040, 32'h0,         7,  1'b0, 32'h0};
    vec[1]  = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0,  1'b0, 32'h0};
    vec[2]  = '{1'b0, 32'h0000_0044, 32'h0,         0,  1'b0, 32'h0};
    vec[3]  = '{1'b0, 32'h0000_0240, 32'h0,         7,  1'b0, 32'h0};
    vec[4]  = '{1'b0, 32'h0000_0440, 32'h0,         13, 1'b1, 32'h40};
    vec[5]  = '{1'b0, 32'h0000_0044, 32'h0,         7,  1'b0, 32'h0};
    vec[6]  = '{1'b0, 32'h0000_005C, 32'h0,         0,  1'b0, 32'h0};
    vec[7]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 7,  1'b0, 32'h0};
    vec[8]  = '{1'b0, 32'h0000_0100, 32'h0,         0,  1'b0, 32'h0};
    vec[9]  = '{1'b0, 32'h0000_011C, 32'h0,         0,  1'b0, 32'h0};
    vec[10] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 0,  1'b0, 32'h0};
    vec[11] = '{1'b0, 32'h0000_0840, 32'h0,         7,  1'b0, 32'h0};
    vec[12] = '{1'b0, 32'h0000_1000, 32'h0,         7,  1'b0, 32'h0};
    vec[13] = '{1'b0, 32'h0000_0044, 32'h0,         7,  1'b0, 32'h0};
    vec[14] = '{1'b1, 32'h0000_0C44, 32'h0BAD_F00D, 0,  1'b0, 32'h0};
    vec[15] = '{1'b0, 32'h0000_0048, 32'h0,         0,  1'b0, 32'h0};
    vec[16] = '{1'b0, 32'h0000_0240, 32'h0,         13, 1'b1, 32'hC40};

    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_mem_we", 256'(mem_we_o), 256'(0));
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_sram_en", 256'(sram_enable_o), 256'(0));

    for (int i = 0; i < 12; i++) access(vec[i]);

    // Dirty victim 0x40 with a slow write-back: outputs must hold
    wb_lat = 10;
    hv = '{1'b0, 32'h0000_0C40, 32'h0, 19, 1'b1, 32'h40};
    fork
      access(hv);
      begin
        t = 0;
        while (!(mem_req_o && mem_we_o) && t < 100) begin
          @(negedge clk_i);
          t++;
        end
        chk("wb_seen", 256'(t < 100), 256'(1));
        a0 = mem_addr_o;
        d0 = mem_data_o;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk_i);
          chk("wb_hold_req", 256'({mem_req_o, mem_we_o}), 256'(2'b11));
          chk("wb_hold_addr", 256'(mem_addr_o), 256'(a0));
          chk("wb_hold_data", mem_data_o, d0);
        end
      end
    join
    wb_lat = 4;

    // Stray ack while idle
    @(negedge clk_i);
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    chk("stray_ack_req", 256'(mem_req_o), 256'(0));
    chk("stray_ack_stall", 256'(cpu_stall_o), 256'(0));

    // Reset during the second REFILL cycle
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_1000;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("refill2_req", 256'({mem_req_o, mem_we_o}), 256'(2'b10));
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_req", 256'(mem_req_o), 256'(0));
    chk("midrst_we", 256'(mem_we_o), 256'(0));
    chk("midrst_stall", 256'(cpu_stall_o), 256'(0));
    rst_i    = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    exp_wb   = 0;
    mem_log.delete();

    for (int i = 12; i < 17; i++) access(vec[i]);

`ifdef DCACHE_MISS_CTRL_PERF_EN
    chk("perf_hit", 256'(perf_hit_o), 256'(exp_hit));
    chk("perf_miss", 256'(perf_miss_o), 256'(exp_miss));
    chk("perf_wb", 256'(perf_wb_o), 256'(exp_wb));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
